// File: rtl/pair_reduce_engine.sv
// Pair reduction engine: streams paired reads from two equal-length word memories,
// tracks the memory read latency with a valid pipeline and folds each element pair
// into a wide accumulator under a selectable mode.
module pair_reduce_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned SUM_W  = 48,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic              rd_en,
  input  logic [DATA_W-1:0] data1_out,
  input  logic [DATA_W-1:0] data2_out,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  SUM,
  output logic              overflow
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [1:0]        mode_q, mode_d;
  logic              rd_en_q, rd_en_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] abs_diff;
  logic [SUM_W-1:0]  a_ext, b_ext, term;
  logic [SUM_W:0]    add_ext;
  logic              step_ovf;

  // Per-pair term and the accumulator update it would produce, with its overflow.
  always_comb begin
    a_ext    = SUM_W'(data1_out);
    b_ext    = SUM_W'(data2_out);
    abs_diff = (data1_out >= data2_out) ? (data1_out - data2_out) : (data2_out - data1_out);
    term     = '0;
    unique case (mode_q)
      2'd0: term = SUM_W'(abs_diff);
      2'd1: term = a_ext - b_ext;
      2'd2: term = SUM_W'(data1_out == data2_out);
      2'd3: term = (data1_out == data2_out) ? a_ext : '0;
    endcase
    add_ext = {1'b0, sum_q} + {1'b0, term};
    if (mode_q == 2'd1) begin
      // Signed overflow: operands agree in sign but the result does not.
      step_ovf = (sum_q[SUM_W-1] == term[SUM_W-1]) && (add_ext[SUM_W-1] != sum_q[SUM_W-1]);
    end else begin
      step_ovf = add_ext[SUM_W];
    end
  end

  // Valid pipeline: rd_en delayed by the memory read latency.
  always_comb begin
    vld_d[0] = rd_en_q;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  // Next-state logic for the control FSM and the accumulator.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    mode_d  = mode_q;
    rd_en_d = rd_en_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;

    if (vld_q[RD_LAT-1]) begin
      sum_d = add_ext[SUM_W-1:0];
      ovf_d = ovf_q | step_ovf;
    end

    unique case (state_q)
      StIdle: begin
        if (go) begin
          mode_d = mode;
          len_d  = length;
          sum_d  = '0;
          ovf_d  = 1'b0;
          addr_d = '0;
          if (length != '0) begin
            rd_en_d = 1'b1;
            state_d = StIssue;
          end else begin
            // Empty run passes through an already-empty drain so done lands one
            // cycle later, matching the edge-1 completion of a zero-length run.
            state_d = StDrain;
          end
        end
      end
      StIssue: begin
        if (addr_q == len_q - 1'b1) begin
          rd_en_d = 1'b0;
          state_d = StDrain;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StDrain: begin
        if (vld_q == '0) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      mode_q  <= 2'd0;
      rd_en_q <= 1'b0;
      vld_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      rd_en_q <= rd_en_d;
      vld_q   <= vld_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign addr1    = addr_q;
  assign addr2    = addr_q;
  assign rd_en    = rd_en_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign SUM      = sum_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pair_reduce_engine.sv
// Scoreboard bench: two engines (RD_LAT=1/SUM_W=48 and RD_LAT=3/SUM_W=33) fed by
// behavioural latency-accurate memories; runs push expectations, monitors pop on done.
module tb_pair_reduce_engine;
  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int SWA  = 48;
  localparam int LATA = 1;
  localparam int SWB  = 33;
  localparam int LATB = 3;

  typedef struct {
    logic [63:0] sum;
    logic        ovf;
    int unsigned done_edge;
    int unsigned reads;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  exp_t q_a[$];
  exp_t q_b[$];

  // DUT A signals
  logic          go_a = 1'b0;
  logic [1:0]    mode_a = 2'd0;
  logic [AW-1:0] len_a = '0;
  logic [AW-1:0] addr1_a, addr2_a;
  logic          rd_en_a, busy_a, done_a, ovf_a;
  logic [DW-1:0] d1_a, d2_a;
  logic [SWA-1:0] sum_a;
  // DUT B signals
  logic          go_b = 1'b0;
  logic [1:0]    mode_b = 2'd0;
  logic [AW-1:0] len_b = '0;
  logic [AW-1:0] addr1_b, addr2_b;
  logic          rd_en_b, busy_b, done_b, ovf_b;
  logic [DW-1:0] d1_b, d2_b;
  logic [SWB-1:0] sum_b;

  pair_reduce_engine #(.DATA_W(DW), .ADDR_W(AW), .SUM_W(SWA), .RD_LAT(LATA)) u_dut_a (
    .clk(clk), .reset(reset), .go(go_a), .mode(mode_a), .length(len_a),
    .addr1(addr1_a), .addr2(addr2_a), .rd_en(rd_en_a),
    .data1_out(d1_a), .data2_out(d2_a),
    .busy(busy_a), .done(done_a), .SUM(sum_a), .overflow(ovf_a)
  );

  pair_reduce_engine #(.DATA_W(DW), .ADDR_W(AW), .SUM_W(SWB), .RD_LAT(LATB)) u_dut_b (
    .clk(clk), .reset(reset), .go(go_b), .mode(mode_b), .length(len_b),
    .addr1(addr1_b), .addr2(addr2_b), .rd_en(rd_en_b),
    .data1_out(d1_b), .data2_out(d2_b),
    .busy(busy_b), .done(done_b), .SUM(sum_b), .overflow(ovf_b)
  );

  // Memories with RD_LAT-stage registered read paths.
  logic [DW-1:0] mem_a1 [8];
  logic [DW-1:0] mem_a2 [8];
  logic [DW-1:0] mem_b1 [8];
  logic [DW-1:0] mem_b2 [8];
  logic [AW-1:0] ap_a [LATA];
  logic [AW-1:0] ap_b [LATB];

  always @(posedge clk) begin
    ap_a[0] <= addr1_a;
    for (int i = 1; i < LATA; i++) ap_a[i] <= ap_a[i-1];
    ap_b[0] <= addr1_b;
    for (int i = 1; i < LATB; i++) ap_b[i] <= ap_b[i-1];
  end

  assign d1_a = mem_a1[ap_a[LATA-1][2:0]];
  assign d2_a = mem_a2[ap_a[LATA-1][2:0]];
  assign d1_b = mem_b1[ap_b[LATB-1][2:0]];
  assign d2_b = mem_b2[ap_b[LATB-1][2:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor A: checks every read address and pops an expectation on each done.
  int unsigned rd_a = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      rd_a = 0;
    end else begin
      if (rd_en_a) begin
        check("addr1_a", 64'(addr1_a), 64'(rd_a));
        check("addr2_a", 64'(addr2_a), 64'(rd_a));
        rd_a++;
      end
      if (done_a) begin
        if (q_a.size() == 0) begin
          check("unexpected_done_a", 64'(1), 64'(0));
        end else begin
          e = q_a.pop_front();
          check("sum_a", 64'(sum_a), e.sum);
          check("ovf_a", 64'(ovf_a), 64'(e.ovf));
          check("done_edge_a", 64'(edge_cnt), 64'(e.done_edge));
          check("reads_a", 64'(rd_a), 64'(e.reads));
        end
        rd_a = 0;
      end
    end
  end

  // Monitor B: same checks for the long-latency, narrow-accumulator engine.
  int unsigned rd_b = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      rd_b = 0;
    end else begin
      if (rd_en_b) begin
        check("addr1_b", 64'(addr1_b), 64'(rd_b));
        check("addr2_b", 64'(addr2_b), 64'(rd_b));
        rd_b++;
      end
      if (done_b) begin
        if (q_b.size() == 0) begin
          check("unexpected_done_b", 64'(1), 64'(0));
        end else begin
          e = q_b.pop_front();
          check("sum_b", 64'(sum_b), e.sum);
          check("ovf_b", 64'(ovf_b), 64'(e.ovf));
          check("done_edge_b", 64'(edge_cnt), 64'(e.done_edge));
          check("reads_b", 64'(rd_b), 64'(e.reads));
        end
        rd_b = 0;
      end
    end
  end

  task automatic chk_rst_a();
    check("rst_addr1_a", 64'(addr1_a), 64'(0));
    check("rst_addr2_a", 64'(addr2_a), 64'(0));
    check("rst_rd_en_a", 64'(rd_en_a), 64'(0));
    check("rst_busy_a", 64'(busy_a), 64'(0));
    check("rst_done_a", 64'(done_a), 64'(0));
    check("rst_sum_a", 64'(sum_a), 64'(0));
    check("rst_ovf_a", 64'(ovf_a), 64'(0));
  endtask

  task automatic chk_rst_b();
    check("rst_addr1_b", 64'(addr1_b), 64'(0));
    check("rst_rd_en_b", 64'(rd_en_b), 64'(0));
    check("rst_busy_b", 64'(busy_b), 64'(0));
    check("rst_done_b", 64'(done_b), 64'(0));
    check("rst_sum_b", 64'(sum_b), 64'(0));
    check("rst_ovf_b", 64'(ovf_b), 64'(0));
  endtask

  // Issue one run; mode/length are scrambled after acceptance, and with ghost set
  // a second go is pulsed mid-run.
  task automatic run(input bit sel, input logic [1:0] m, input int unsigned l,
                     input logic [63:0] es, input logic eo, input bit ghost);
    exp_t e;
    bit seen;
    int unsigned lat;
    lat = sel ? LATB : LATA;
    @(negedge clk);
    e.sum = es;
    e.ovf = eo;
    e.reads = l;
    e.done_edge = edge_cnt + 1 + ((l == 0) ? 1 : l + lat + 1);
    if (sel) begin
      q_b.push_back(e); go_b = 1'b1; mode_b = m; len_b = AW'(l);
    end else begin
      q_a.push_back(e); go_a = 1'b1; mode_a = m; len_a = AW'(l);
    end
    @(negedge clk);
    if (sel) begin
      go_b = 1'b0; mode_b = m + 2'd1; len_b = AW'(l + 3);
      check("busy_run_b", 64'(busy_b), 64'(1));
    end else begin
      go_a = 1'b0; mode_a = m + 2'd1; len_a = AW'(l + 3);
      check("busy_run_a", 64'(busy_a), 64'(1));
    end
    if (ghost) begin
      @(negedge clk);
      if (sel) go_b = 1'b1; else go_a = 1'b1;
      @(negedge clk);
      go_b = 1'b0;
      go_a = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = sel ? done_b : done_a;
    end
    if (!seen) check("done_timeout", 64'(0), 64'(1));
    @(negedge clk);
    check(sel ? "busy_after_b" : "busy_after_a", 64'(sel ? busy_b : busy_a), 64'(0));
  endtask

  initial begin
    bit hit;
    mem_a1 = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3, 32'd4, 32'd0, 32'd0};
    mem_a2 = '{32'd3, 32'd3, 32'd3, 32'd4, 32'd5, 32'd9, 32'd0, 32'd0};
    mem_b1 = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    mem_b2 = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

    repeat (3) @(negedge clk);
    chk_rst_a();
    chk_rst_b();
    reset = 1'b1;

    // |a-b| = 2+1+0+1+2+5
    run(1'b0, 2'd0, 6, 64'd11, 1'b0, 1'b0);
    // a-b = -11 at 48 bits
    run(1'b0, 2'd1, 6, 64'h0000_FFFF_FFFF_FFF5, 1'b0, 1'b0);
    run(1'b0, 2'd2, 6, 64'd1, 1'b0, 1'b0);
    run(1'b0, 2'd3, 6, 64'd3, 1'b0, 1'b0);
    run(1'b0, 2'd0, 0, 64'd0, 1'b0, 1'b0);

    // 3 * 0xFFFFFFFF = 0x2FFFFFFFD, wraps at 33 bits to 0x0FFFFFFFD with carry out
    run(1'b1, 2'd0, 3, 64'h0_FFFF_FFFD, 1'b1, 1'b1);
    // second add crosses the 33-bit signed range; third wraps back, flag stays sticky
    run(1'b1, 2'd1, 3, 64'h0_FFFF_FFFD, 1'b1, 1'b0);
    run(1'b1, 2'd2, 3, 64'd0, 1'b0, 1'b0);

    // Abort a run with reset at addr 3; nothing is pushed, so any done is flagged.
    @(negedge clk);
    go_a = 1'b1; mode_a = 2'd1; len_a = AW'(6);
    @(negedge clk);
    go_a = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (rd_en_a && addr1_a == AW'(3)) hit = 1'b1;
      else @(negedge clk);
    end
    check("reach_addr3", 64'(hit), 64'(1));
    reset = 1'b0;
    @(negedge clk);
    chk_rst_a();
    @(negedge clk);
    reset = 1'b1;
    // |1-3| + |2-3|
    run(1'b0, 2'd0, 2, 64'd3, 1'b0, 1'b0);

    repeat (10) @(negedge clk);
    check("sb_empty_a", 64'(q_a.size()), 64'(0));
    check("sb_empty_b", 64'(q_b.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
